pkt_fifo: RTL and testbench

//  Store-and-forward packet FIFO placed directly upstream of each star_arb src port.

---
 rtl/pkt_fifo_pkg.sv | 19 +
 rtl/pkt_fifo_sdp_ram.sv | 47 ++++
 rtl/pkt_fifo.sv | 157 +++++++++++++++
 tb/tb_pkt_fifo.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pkt_fifo_pkg
// Description : Shared constants for the store-and-forward packet FIFO:
//               RAM word side-band width and PASS/DROP state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package pkt_fifo_pkg;

    // Side-band bits stored next to TDATA in every RAM word (TLAST only)
    localparam int unsigned c_LAST_W = 1;

    // Drop state machine encoding
    localparam int unsigned c_STATE_W = 1;
    localparam logic [c_STATE_W-1:0] c_ST_PASS = 1'b0;
    localparam logic [c_STATE_W-1:0] c_ST_DROP = 1'b1;

endpackage
`default_nettype wire

// File: rtl/pkt_fifo_sdp_ram.sv
`default_nettype none
// ============================================================================
// Module      : pkt_fifo_sdp_ram
// Description : Simple dual-port RAM, one write port and one read port,
//               1-cycle registered read. The read register holds its value
//               while i_rd_en is low so it can act as the FIFO output stage.
// Revision    : 1.0 - initial release
// ============================================================================
module pkt_fifo_sdp_ram
    import pkt_fifo_pkg::*;
#(
    parameter int WORD_WIDTH = 64 + c_LAST_W,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [WORD_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [WORD_WIDTH-1:0] o_rd_data
);

    logic [WORD_WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];
    logic [WORD_WIDTH-1:0] r_rd_data;

    // Storage array write port
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Registered read; cleared on reset so the output data starts at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/pkt_fifo.sv
`default_nettype none
// ============================================================================
// Module      : pkt_fifo
// Description : Store-and-forward AXI-Stream packet FIFO. A packet becomes
//               visible downstream only after its TLAST word is stored, so
//               it then streams without bubbles. The RAM read register is
//               the first-word-fall-through output stage.
//               Optional feature macro PKT_FIFO_DROP_EN: a partial packet
//               that overflows the FIFO is discarded (drop pulse) instead of
//               stalling the producer forever.
// Revision    : 1.0 - initial release
// ============================================================================
module pkt_fifo
    import pkt_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_TDATA,
    input  logic                  in_TVALID,
    output logic                  in_TREADY,
    input  logic                  in_TLAST,
    output logic [DATA_WIDTH-1:0] out_TDATA,
    output logic                  out_TVALID,
    input  logic                  out_TREADY,
    output logic                  out_TLAST,
    output logic [ADDR_WIDTH:0]   occupancy,
    output logic                  drop
);

    localparam int c_WORD_W = DATA_WIDTH + c_LAST_W;
    localparam logic [ADDR_WIDTH:0] c_DEPTH   = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] c_PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    // Pointers carry an extra wrap bit. r_rd_ptr marks the word presented on
    // the output (its slot stays occupied until accepted); r_fetch_ptr is the
    // next committed word to pull into the output register.
    logic [ADDR_WIDTH:0] r_wr_ptr;
    logic [ADDR_WIDTH:0] r_wr_commit;
    logic [ADDR_WIDTH:0] r_rd_ptr;
    logic [ADDR_WIDTH:0] r_fetch_ptr;
    logic [ADDR_WIDTH:0] r_occupancy;
    logic                r_out_vld;

    logic [ADDR_WIDTH:0] w_wr_ptr_nxt;
    logic [ADDR_WIDTH:0] w_wr_commit_nxt;
    logic [ADDR_WIDTH:0] w_rd_ptr_nxt;
    logic                w_full;
    logic                w_in_ready;
    logic                w_wr_en;
    logic                w_rd_en;
    logic                w_pop;
    logic                w_drop_start;
    logic [c_WORD_W-1:0] w_rd_word;

    assign w_full = (r_wr_ptr - r_rd_ptr) == c_DEPTH;
    assign w_pop  = r_out_vld && out_TREADY;
    // Refill the output stage whenever it is empty or being emptied this cycle
    assign w_rd_en = (r_fetch_ptr != r_wr_commit) && (!r_out_vld || out_TREADY);
    assign w_rd_ptr_nxt = w_pop ? (r_rd_ptr + c_PTR_ONE) : r_rd_ptr;

`ifdef PKT_FIFO_DROP_EN
    logic [c_STATE_W-1:0] r_state;
    logic                 r_drop;

    // Overflow with an uncommitted packet in flight: discard it
    assign w_drop_start = (r_state == c_ST_PASS) && w_full && in_TVALID
                          && (r_wr_ptr != r_wr_commit);
    assign w_in_ready   = (r_state == c_ST_DROP) || !w_full;
    assign w_wr_en      = in_TVALID && w_in_ready && (r_state == c_ST_PASS);

    // PASS/DROP control: swallow the rest of a dropped packet through TLAST
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_PASS;
            r_drop  <= 1'b0;
        end else begin
            r_drop <= w_drop_start;
            case (r_state)
                c_ST_PASS: if (w_drop_start) r_state <= c_ST_DROP;
                c_ST_DROP: if (in_TVALID && in_TLAST) r_state <= c_ST_PASS;
                default:   r_state <= c_ST_PASS;
            endcase
        end
    end

    assign drop = r_drop;
`else
    assign w_drop_start = 1'b0;
    assign w_in_ready   = !w_full;
    assign w_wr_en      = in_TVALID && w_in_ready;
    assign drop         = 1'b0;
`endif

    // Next write/commit pointers; a drop rewinds the write pointer to the
    // last packet boundary
    always_comb begin
        w_wr_ptr_nxt    = r_wr_ptr;
        w_wr_commit_nxt = r_wr_commit;
        if (w_wr_en) begin
            w_wr_ptr_nxt = r_wr_ptr + c_PTR_ONE;
            if (in_TLAST) begin
                w_wr_commit_nxt = r_wr_ptr + c_PTR_ONE;
            end
        end
        if (w_drop_start) begin
            w_wr_ptr_nxt = r_wr_commit;
        end
    end

    // Pointer, occupancy and output-valid state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_wr_commit <= '0;
            r_rd_ptr    <= '0;
            r_fetch_ptr <= '0;
            r_occupancy <= '0;
            r_out_vld   <= 1'b0;
        end else begin
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_wr_commit <= w_wr_commit_nxt;
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_occupancy <= w_wr_ptr_nxt - w_rd_ptr_nxt;
            if (w_rd_en) begin
                r_fetch_ptr <= r_fetch_ptr + c_PTR_ONE;
                r_out_vld   <= 1'b1;
            end else if (w_pop) begin
                r_out_vld   <= 1'b0;
            end
        end
    end

    pkt_fifo_sdp_ram #(
        .WORD_WIDTH (c_WORD_W),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wr_ptr[ADDR_WIDTH-1:0]),
        .i_wr_data ({in_TDATA, in_TLAST}),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (r_fetch_ptr[ADDR_WIDTH-1:0]),
        .o_rd_data (w_rd_word)
    );

    assign in_TREADY  = w_in_ready;
    assign out_TVALID = r_out_vld;
    assign out_TDATA  = w_rd_word[c_WORD_W-1 -: DATA_WIDTH];
    assign out_TLAST  = w_rd_word[0];
    assign occupancy  = r_occupancy;

endmodule
`default_nettype wire

// File: tb/tb_pkt_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_pkt_fifo
// Description : Self-checking bench for pkt_fifo. A packet-level model
//               (pending/committed word queues plus a word count) predicts
//               output order, occupancy, ready and drop behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pkt_fifo;

    localparam int DW    = 64;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] in_TDATA = '0;
    logic          in_TVALID = 1'b0;
    logic          in_TREADY;
    logic          in_TLAST = 1'b0;
    logic [DW-1:0] out_TDATA;
    logic          out_TVALID;
    logic          out_TREADY = 1'b0;
    logic          out_TLAST;
    logic [AW:0]   occupancy;
    logic          drop;

    always #5 clk = ~clk;

    pkt_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_TDATA   (in_TDATA),
        .in_TVALID  (in_TVALID),
        .in_TREADY  (in_TREADY),
        .in_TLAST   (in_TLAST),
        .out_TDATA  (out_TDATA),
        .out_TVALID (out_TVALID),
        .out_TREADY (out_TREADY),
        .out_TLAST  (out_TLAST),
        .occupancy  (occupancy),
        .drop       (drop)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Words are {TDATA, TLAST}
    logic [DW:0] src_q[$];   // producer words not yet accepted
    logic [DW:0] pend_q[$];  // accepted words of the packet still open
    logic [DW:0] exp_q[$];   // committed words, in delivery order
    int occ_m = 0;
    bit dropping_m = 0;
    bit drop_exp = 0;
    bit hold = 0;
    int vld_pct = 100;
    int rdy_pct = 100;
    int cyc = 0;
    int n_pop = 0;
    int n_acc = 0;
    int n_drop = 0;
    int words_pushed = 0;
    int last_acc_cyc = -1;
    int first_vld_cyc = -1;
    int first_pop_cyc = -1;
    int last_pop_cyc = -1;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_pkt(input int len, input bit with_last);
        for (int i = 0; i < len; i++) begin
            src_q.push_back({$urandom, $urandom, (with_last && (i == len - 1))});
            words_pushed++;
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model,
    // advance the model by the handshakes that happen at the coming edge.
    task automatic cycle();
        logic [DW:0] w;
        bit acc;
        bit pop;
        bit was_dropping;
        bit nd;
        int occ0;
        nd = 0;
        was_dropping = dropping_m;
        occ0 = occ_m;
        if (!hold && src_q.size() > 0 && $urandom_range(99) < vld_pct) hold = 1;
        w = hold ? src_q[0] : '0;
        in_TVALID  = hold;
        in_TDATA   = w[DW:1];
        in_TLAST   = w[0];
        out_TREADY = ($urandom_range(99) < rdy_pct);

        chk("occupancy", occupancy, occ0);
        chk("in_TREADY", in_TREADY, (dropping_m || occ0 < DEPTH));
        chk("drop", drop, drop_exp);
        if (out_TVALID) begin
            chk("valid_has_data", (exp_q.size() > 0), 1'b1);
            if (exp_q.size() > 0) chk("out_word", {out_TDATA, out_TLAST}, exp_q[0]);
            if (first_vld_cyc < 0) first_vld_cyc = cyc;
        end
        if (drop) n_drop++;

        acc = in_TVALID && in_TREADY;
        pop = out_TVALID && out_TREADY;
`ifdef PKT_FIFO_DROP_EN
        if (!was_dropping && occ0 == DEPTH && hold && pend_q.size() > 0) begin
            occ_m = occ_m - pend_q.size();
            pend_q.delete();
            dropping_m = 1;
            nd = 1;
        end
`endif
        if (pop) begin
            if (exp_q.size() > 0) exp_q.delete(0);
            occ_m--;
            n_pop++;
            if (first_pop_cyc < 0) first_pop_cyc = cyc;
            last_pop_cyc = cyc;
        end
        if (acc && hold) begin
            w = src_q.pop_front();
            hold = 0;
            n_acc++;
            if (was_dropping) begin
                if (w[0]) dropping_m = 0;
            end else begin
                pend_q.push_back(w);
                occ_m++;
                if (w[0]) begin
                    last_acc_cyc = cyc;
                    foreach (pend_q[k]) exp_q.push_back(pend_q[k]);
                    pend_q.delete();
                end
            end
        end
        drop_exp = nd;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        in_TVALID = 1'b0;
        in_TLAST = 1'b0;
        in_TDATA = '0;
        out_TREADY = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        src_q.delete();
        pend_q.delete();
        exp_q.delete();
        occ_m = 0;
        dropping_m = 0;
        drop_exp = 0;
        hold = 0;
    endtask

    task automatic drain(input int budget);
        int b;
        b = budget;
        vld_pct = 100;
        rdy_pct = 100;
        while ((src_q.size() > 0 || exp_q.size() > 0) && b > 0) begin
            cycle();
            b--;
        end
        chk("drain_left", src_q.size() + exp_q.size(), 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        int p0;
        int a0;
        int vcnt;

        // Reset state
        do_reset(3);
        chk("rst_out_TVALID", out_TVALID, 1'b0);
        chk("rst_out_TLAST", out_TLAST, 1'b0);
        chk("rst_out_TDATA", out_TDATA, 64'd0);
        chk("rst_drop", drop, 1'b0);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_in_TREADY", in_TREADY, 1'b1);

        // Test 1: 4-word packet, latency and contiguous streaming
        for (int i = 0; i < 4; i++) begin
            src_q.push_back({64'(64'hA0 + i), (i == 3)});
        end
        first_vld_cyc = -1;
        first_pop_cyc = -1;
        drain(40);
        chk("latency", first_vld_cyc - last_acc_cyc, 2);
        chk("contiguous", last_pop_cyc - first_pop_cyc, 3);

        // Test 2: open packet stays invisible until TLAST arrives
        push_pkt(3, 0);
        vcnt = 0;
        for (int i = 0; i < 25; i++) begin
            cycle();
            if (out_TVALID) vcnt++;
        end
        chk("partial_hidden", vcnt, 0);
        push_pkt(1, 1);
        drain(40);

        // Test 3: fill to DEPTH with the consumer stalled, then release
        vld_pct = 100;
        rdy_pct = 0;
        for (int p = 0; p < 8; p++) push_pkt(4, 1);
        b = 100;
        while (src_q.size() > 0 && b > 0) begin
            cycle();
            b--;
        end
        repeat (3) cycle();
        chk("full_in_TREADY", in_TREADY, 1'b0);
        chk("full_occupancy", occupancy, DEPTH);
        drain(200);

        // Test 4: output stall mid-packet holds the presented word
        push_pkt(8, 1);
        vld_pct = 100;
        rdy_pct = 100;
        p0 = n_pop;
        b = 50;
        while (n_pop < p0 + 2 && b > 0) begin
            cycle();
            b--;
        end
        rdy_pct = 0;
        repeat (5) cycle();
        chk("stall_valid", out_TVALID, 1'b1);
        if (exp_q.size() > 0) chk("stall_word", {out_TDATA, out_TLAST}, exp_q[0]);
        drain(100);

        // Random traffic on both sides
        words_pushed = 0;
        while (words_pushed < 10000) begin
            if (src_q.size() < 8) push_pkt($urandom_range(1, 8), 1);
            if (cyc % 256 == 0) begin
                vld_pct = $urandom_range(20, 100);
                rdy_pct = $urandom_range(20, 100);
            end
            cycle();
        end
        drain(2000);

        // Test 5: reset in the middle of a packet with two stored packets
        vld_pct = 100;
        rdy_pct = 0;
        for (int p = 0; p < 3; p++) push_pkt(4, 1);
        a0 = n_acc;
        b = 60;
        while (n_acc < a0 + 10 && b > 0) begin
            cycle();
            b--;
        end
        do_reset(1);
        chk("rst_mid_occupancy", occupancy, 0);
        chk("rst_mid_out_TVALID", out_TVALID, 1'b0);
        chk("rst_mid_in_TREADY", in_TREADY, 1'b1);
        push_pkt(5, 1);
        drain(60);

`ifdef PKT_FIFO_DROP_EN
        // Test 6: oversize packet is dropped, next packet passes
        p0 = n_drop;
        push_pkt(40, 1);
        push_pkt(3, 1);
        drain(300);
        chk("drop_pulses", n_drop - p0, 1);
        chk("post_drop_occupancy", occupancy, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
